// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer/burst encodings, widths and burst length helper.
package ahb_pkg;

    localparam int MASTER_W = 4;
    localparam int GRANT_W  = 16;
    localparam int HTRANS_W = 2;
    localparam int HSIZE_W  = 3;
    localparam int HBURST_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    // Beats in a fixed-length burst; SINGLE and undefined-length INCR count as one.
    function automatic logic [4:0] burst_len(input logic [HBURST_W-1:0] b);
        return (b == WRAP16 || b == INCR16) ? 5'd16 :
               (b == WRAP8  || b == INCR8)  ? 5'd8  :
               (b == WRAP4  || b == INCR4)  ? 5'd4  : 5'd1;
    endfunction

endpackage

// File: rtl/ahb_master_mux_if.sv
// ahb_master_mux_if: arbiter inputs, per-master request buses and muxed slave-side bus.
interface ahb_master_mux_if
    import ahb_pkg::*;
#(
    parameter int NMASTERS = 16,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [MASTER_W-1:0]          HMASTER;
    logic                         HMASTLOCK;
    logic [GRANT_W-1:0]           HGRANTx;
    logic                         HREADY;
    logic [NMASTERS*ADDR_W-1:0]   HADDR_M;
    logic [NMASTERS*HTRANS_W-1:0] HTRANS_M;
    logic [NMASTERS-1:0]          HWRITE_M;
    logic [NMASTERS*HSIZE_W-1:0]  HSIZE_M;
    logic [NMASTERS*HBURST_W-1:0] HBURST_M;
    logic [NMASTERS*DATA_W-1:0]   HWDATA_M;
    logic [ADDR_W-1:0]            HADDR;
    logic [HTRANS_W-1:0]          HTRANS;
    logic                         HWRITE;
    logic [HSIZE_W-1:0]           HSIZE;
    logic [HBURST_W-1:0]          HBURST;
    logic                         HMASTLOCK_S;
    logic [DATA_W-1:0]            HWDATA;
    logic [MASTER_W-1:0]          HMASTER_D;
    logic                         DVALID;
    logic                         BURST_BREAK;

    modport master (
        output HMASTER, HMASTLOCK, HGRANTx, HREADY,
               HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HBURST_M, HWDATA_M,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK_S,
               HWDATA, HMASTER_D, DVALID, BURST_BREAK
    );

    modport slave (
        input  HMASTER, HMASTLOCK, HGRANTx, HREADY,
               HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HBURST_M, HWDATA_M,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK_S,
               HWDATA, HMASTER_D, DVALID, BURST_BREAK
    );
endinterface

// File: rtl/ahb_burst_tracker.sv
// ahb_burst_tracker: counts remaining fixed-burst beats and pulses burst_break on an early handover.
module ahb_burst_tracker
    import ahb_pkg::*;
(
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                hready,
    input  logic [MASTER_W-1:0] hmaster,
    input  logic [HTRANS_W-1:0] htrans,
    input  logic [HBURST_W-1:0] hburst,
    output logic                burst_break
);
    logic [3:0]          beats_left;
    logic [3:0]          beats_nxt;
    logic [MASTER_W-1:0] bmaster;
    logic                brk;

    // A pending burst breaks when another master takes the bus or the owner goes IDLE/NONSEQ early.
    always_comb begin
        brk       = hready && beats_left != '0 && (hmaster != bmaster || htrans == IDLE || htrans == NONSEQ);
        beats_nxt = (htrans == NONSEQ) ? 4'(burst_len(hburst) - 5'd1) :
                    brk ? '0 :
                    (htrans == BUSY) ? beats_left :
                    (htrans == SEQ && beats_left != '0) ? beats_left - 4'd1 : '0;
    end

    // Tracker state advances only on accepted transfers; the break flag is a registered pulse.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beats_left  <= '0;
            bmaster     <= '0;
            burst_break <= 1'b0;
        end else begin
            burst_break <= brk;
            if (hready) begin
                beats_left <= beats_nxt;
                if (htrans == NONSEQ) bmaster <= hmaster;
            end
        end
    end
endmodule

// File: rtl/ahb_master_mux.sv
// ahb_master_mux: routes address-phase owner's control and data-phase owner's write data to slaves.
// Optional feature AHB_MUX_IDLE_ON_NOGRANT_EN: force HTRANS to IDLE while HGRANTx is all zero.
module ahb_master_mux
    import ahb_pkg::*;
#(
    parameter int NMASTERS = 16,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input logic             HCLK,
    input logic             HRESETn,
    ahb_master_mux_if.slave bus
);
    logic                sel_ok;
    logic [MASTER_W-1:0] asel;
    logic [MASTER_W-1:0] dsel;
    logic [MASTER_W-1:0] dmaster;
    logic                dvalid;
    logic [HTRANS_W-1:0] htrans;

    // Out-of-range owners are presented as master 0 issuing IDLE.
    assign sel_ok = {1'b0, bus.HMASTER} < 5'(NMASTERS);
    assign asel   = sel_ok ? bus.HMASTER : '0;

`ifdef AHB_MUX_IDLE_ON_NOGRANT_EN
    assign htrans = (!sel_ok || bus.HGRANTx == '0) ? IDLE : bus.HTRANS_M[int'(asel)*HTRANS_W +: HTRANS_W];
`else
    assign htrans = !sel_ok ? IDLE : bus.HTRANS_M[int'(asel)*HTRANS_W +: HTRANS_W];
`endif

    assign bus.HADDR       = bus.HADDR_M[int'(asel)*ADDR_W +: ADDR_W];
    assign bus.HTRANS      = htrans;
    assign bus.HWRITE      = bus.HWRITE_M[asel];
    assign bus.HSIZE       = bus.HSIZE_M[int'(asel)*HSIZE_W +: HSIZE_W];
    assign bus.HBURST      = bus.HBURST_M[int'(asel)*HBURST_W +: HBURST_W];
    assign bus.HMASTLOCK_S = bus.HMASTLOCK;

    // Data-phase owner and validity follow the address phase by one HREADY-high edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dmaster <= '0;
            dvalid  <= 1'b0;
        end else if (bus.HREADY) begin
            dmaster <= bus.HMASTER;
            dvalid  <= htrans[1];
        end
    end

    assign dsel          = ({1'b0, dmaster} < 5'(NMASTERS)) ? dmaster : '0;
    assign bus.HWDATA    = bus.HWDATA_M[int'(dsel)*DATA_W +: DATA_W];
    assign bus.HMASTER_D = dmaster;
    assign bus.DVALID    = dvalid;

    ahb_burst_tracker u_trk (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .hready      (bus.HREADY),
        .hmaster     (bus.HMASTER),
        .htrans      (htrans),
        .hburst      (bus.HBURST),
        .burst_break (bus.BURST_BREAK)
    );
endmodule

// File: tb/tb_ahb_master_mux.sv
// tb_ahb_master_mux: directed and random checks of ahb_master_mux against a transaction-level model.
module tb_ahb_master_mux;
    localparam int N = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int n_asrt  = 0;
    int n_fail  = 0;

    logic [31:0] addr  [N];
    logic [1:0]  trans [N];
    logic        wr    [N];
    logic [2:0]  size  [N];
    logic [2:0]  burst [N];
    logic [31:0] wdata [N];

    int   lens [8] = '{1, 1, 4, 4, 8, 8, 16, 16};
    int   m_dmaster;
    int   m_left;
    int   m_owner;
    logic m_dvalid;
    logic m_brk;
    int   mr;

    ahb_master_mux_if bus();

    ahb_master_mux dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_trans();
`ifdef AHB_MUX_IDLE_ON_NOGRANT_EN
        if (bus.HGRANTx == 16'h0) return 0;
`endif
        return int'(trans[bus.HMASTER]);
    endfunction

    task automatic model_reset();
        m_dmaster = 0;
        m_dvalid  = 1'b0;
        m_left    = 0;
        m_owner   = 0;
        m_brk     = 1'b0;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.HADDR_M[i*32 +: 32] = addr[i];
            bus.HTRANS_M[i*2 +: 2]  = trans[i];
            bus.HWRITE_M[i]         = wr[i];
            bus.HSIZE_M[i*3 +: 3]   = size[i];
            bus.HBURST_M[i*3 +: 3]  = burst[i];
            bus.HWDATA_M[i*32 +: 32] = wdata[i];
        end
        #1;
    endtask

    task automatic set(input int m, input logic [1:0] t, input logic [2:0] b);
        trans[m]    = t;
        burst[m]    = b;
        bus.HMASTER = 4'(m);
        apply();
    endtask

    // Model: remember the data-phase owner and the beats a fixed burst still owes.
    task automatic tick();
        int t = eff_trans();
        int m = int'(bus.HMASTER);
        if (rst_n && bus.HREADY) begin
            m_brk     = (m_left != 0) && (m != m_owner || t == 0 || t == 2);
            m_dmaster = m;
            m_dvalid  = (t >= 2);
            if (t == 2) begin
                m_left  = lens[burst[m]] - 1;
                m_owner = m;
            end else if (m_brk || t == 0) m_left = 0;
            else if (t == 3 && m_left > 0) m_left--;
        end else m_brk = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_comb();
        int m = int'(bus.HMASTER);
        chk("haddr",   64'(bus.HADDR),       64'(addr[m]));
        chk("htrans",  64'(bus.HTRANS),      64'(eff_trans()));
        chk("hwrite",  64'(bus.HWRITE),      64'(wr[m]));
        chk("hsize",   64'(bus.HSIZE),       64'(size[m]));
        chk("hburst",  64'(bus.HBURST),      64'(burst[m]));
        chk("hmlock",  64'(bus.HMASTLOCK_S), 64'(bus.HMASTLOCK));
    endtask

    task automatic chk_regs();
        chk("dvalid",    64'(bus.DVALID),      64'(m_dvalid));
        chk("hmaster_d", 64'(bus.HMASTER_D),   64'(m_dmaster));
        chk("hwdata",    64'(bus.HWDATA),      64'(wdata[m_dmaster]));
        chk("brk",       64'(bus.BURST_BREAK), 64'(m_brk));
    endtask

    initial begin
        model_reset();
        bus.HMASTER   = 4'd0;
        bus.HMASTLOCK = 1'b0;
        bus.HGRANTx   = 16'hFFFF;
        bus.HREADY    = 1'b1;
        for (int i = 0; i < N; i++) begin
            addr[i]  = $urandom;
            trans[i] = 2'd0;
            wr[i]    = 1'($urandom_range(0, 1));
            size[i]  = 3'($urandom_range(0, 7));
            burst[i] = 3'($urandom_range(0, 7));
            wdata[i] = $urandom;
        end
        apply();
        chk_regs();
        chk("rst_dvalid", 64'(bus.DVALID), 64'd0);
        chk("rst_hmd",    64'(bus.HMASTER_D), 64'd0);
        chk("rst_hwdata", 64'(bus.HWDATA), 64'(wdata[0]));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pipelined write: master 3 address phase, then master 5 takes the address bus.
        wr[3] = 1'b1;
        set(3, 2'd2, 3'd0);
        chk_comb();
        tick();
        set(5, 2'd0, 3'd0);
        chk_comb();
        chk_regs();
        chk("pipe_hmd",    64'(bus.HMASTER_D), 64'd3);
        chk("pipe_hwdata", 64'(bus.HWDATA), 64'(wdata[3]));
        chk("pipe_dvalid", 64'(bus.DVALID), 64'd1);

        // Wait states hold the data-phase selection while HMASTER moves to 7.
        bus.HREADY = 1'b0;
        set(7, 2'd2, 3'd0);
        repeat (4) begin
            chk_comb();
            tick();
            chk_regs();
            chk("wait_hmd", 64'(bus.HMASTER_D), 64'd3);
            chk("wait_brk", 64'(bus.BURST_BREAK), 64'd0);
        end
        bus.HREADY = 1'b1;
        tick();
        chk_regs();
        chk("wait_rel_hmd", 64'(bus.HMASTER_D), 64'd7);

        // Clean INCR4 with a BUSY beat, then a new master.
        foreach (lens[k]) if (k < 5) begin
            set(2, (k == 0) ? 2'd2 : (k == 2) ? 2'd1 : 2'd3, 3'd3);
            chk_comb();
            tick();
            chk_regs();
            chk("incr4_brk", 64'(bus.BURST_BREAK), 64'd0);
        end
        set(9, 2'd2, 3'd0);
        tick();
        chk_regs();
        chk("incr4_done_brk", 64'(bus.BURST_BREAK), 64'd0);

        // Broken INCR8: master 4 steals the bus after three beats.
        set(1, 2'd2, 3'd5);
        tick();
        set(1, 2'd3, 3'd5);
        tick();
        tick();
        set(4, 2'd2, 3'd3);
        chk_comb();
        tick();
        chk_regs();
        chk("break_pulse", 64'(bus.BURST_BREAK), 64'd1);
        set(4, 2'd3, 3'd3);
        repeat (3) begin
            tick();
            chk_regs();
            chk("break_once", 64'(bus.BURST_BREAK), 64'd0);
        end

        // Reset in the middle of an INCR8 clears the tracker.
        set(1, 2'd2, 3'd5);
        tick();
        set(1, 2'd3, 3'd5);
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_dvalid", 64'(bus.DVALID), 64'd0);
        chk("mid_rst_hmd",    64'(bus.HMASTER_D), 64'd0);
        chk("mid_rst_brk",    64'(bus.BURST_BREAK), 64'd0);
        trans[1] = 2'd0;
        set(0, 2'd0, 3'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_regs();
        chk("post_rst_dvalid", 64'(bus.DVALID), 64'd0);
        chk("post_rst_brk",    64'(bus.BURST_BREAK), 64'd0);
        set(4, 2'd2, 3'd0);
        tick();
        chk_regs();
        chk("post_rst_nobrk", 64'(bus.BURST_BREAK), 64'd0);

        // No grant: HTRANS forced IDLE only with the optional feature.
        bus.HGRANTx = 16'h0;
        set(6, 2'd2, 3'd0);
`ifdef AHB_MUX_IDLE_ON_NOGRANT_EN
        chk("nogrant_htrans", 64'(bus.HTRANS), 64'd0);
`else
        chk("nogrant_htrans", 64'(bus.HTRANS), 64'd2);
`endif
        chk_comb();
        tick();
        chk_regs();
        bus.HGRANTx = 16'hFFFF;

        // Random traffic: mostly continuing bursts, occasional handovers, wait states and grant drops.
        for (int k = 0; k < 400; k++) begin
            mr = int'(bus.HMASTER);
            if ($urandom_range(0, 3) == 0) begin
                mr        = $urandom_range(0, N - 1);
                trans[mr] = 2'($urandom_range(0, 3));
                burst[mr] = 3'($urandom_range(0, 7));
            end else trans[mr] = ($urandom_range(0, 4) == 0) ? 2'd1 : 2'd3;
            addr[mr] = $urandom;
            wdata[$urandom_range(0, N - 1)] = $urandom;
            bus.HMASTER   = 4'(mr);
            bus.HREADY    = ($urandom_range(0, 3) != 0);
            bus.HMASTLOCK = 1'($urandom_range(0, 1));
            bus.HGRANTx   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'(1 << mr);
            apply();
            chk_comb();
            tick();
            chk_regs();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_master_mux.md
# ahb_master_mux

Master-to-slave multiplexer for the AHB-Lite fabric, sitting directly downstream of the AHB arbiter. It consumes `HMASTER`, `HMASTLOCK`, `HGRANTx` and `HREADY`, and routes the address/control of the address-phase owner to the shared slave bus. Write data is routed from the data-phase owner through an `HREADY`-qualified pipeline register. It also tracks fixed-length bursts and flags any handover that breaks a burst before its last beat.

## Interface
Parameters:
- `NMASTERS`, default 16: number of masters; must match the arbiter (16).
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `HCLK` in 1: bus clock.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `HMASTER` in 4: address-phase owner, from the arbiter.
- `HMASTLOCK` in 1: locked-transfer indication, from the arbiter.
- `HGRANTx` in 16: one-hot grant vector, from the arbiter.
- `HREADY` in 1: shared transfer-done from the slave mux.
- `HADDR_M` in `NMASTERS*ADDR_W`: per-master address; master i at slice [i*ADDR_W +: ADDR_W].
- `HTRANS_M` in `NMASTERS*2`: per-master transfer type, same slicing.
- `HWRITE_M` in `NMASTERS`: per-master write flag.
- `HSIZE_M` in `NMASTERS*3`: per-master size.
- `HBURST_M` in `NMASTERS*3`: per-master burst type.
- `HWDATA_M` in `NMASTERS*DATA_W`: per-master write data.
- `HADDR` out `ADDR_W`: muxed address.
- `HTRANS` out 2: muxed transfer type.
- `HWRITE` out 1: muxed write flag.
- `HSIZE` out 3: muxed size.
- `HBURST` out 3: muxed burst type.
- `HMASTLOCK_S` out 1: lock to slaves.
- `HWDATA` out `DATA_W`: muxed write data.
- `HMASTER_D` out 4: data-phase owner.
- `DVALID` out 1: data phase active (a NONSEQ or SEQ was accepted).
- `BURST_BREAK` out 1: one-cycle pulse marking an illegal handover.

## Operation
- Address/control outputs are combinational, selected by `HMASTER`. `HMASTLOCK_S` = `HMASTLOCK`.
- Data-phase registers (`dmaster`, `dvalid`) load only when `HREADY`=1:
  - `dmaster` <= `HMASTER`.
  - `dvalid` <= (`HTRANS` is NONSEQ or SEQ).
  - While `HREADY`=0 both hold.
- `HWDATA` = `HWDATA_M` slice selected by `dmaster`. `HMASTER_D` = `dmaster`. `DVALID` = `dvalid`.
- Burst tracker:
  - State: `beats_left` (4 bits), `bmaster` (4 bits).
  - On an accepted NONSEQ (`HREADY`=1) with a fixed burst: `beats_left` <= length−1 (WRAP4/INCR4 → 3, 8-beat → 7, 16-beat → 15), `bmaster` <= `HMASTER`.
  - SINGLE or INCR: `beats_left` <= 0.
  - Accepted SEQ: decrement (saturates at 0).
  - BUSY holds the count.
- Break condition: `HREADY`=1, `beats_left`≠0, and either `HMASTER`≠`bmaster` or `HTRANS`∈{IDLE, NONSEQ}.
  - Response: `BURST_BREAK`=1 in the following cycle (registered), and `beats_left` is reloaded per the current transfer (0 if IDLE).
  - `BURST_BREAK` is suppressed when `HMASTLOCK`=0 and the burst was INCR — that case cannot reach here, since INCR counts 0.
- Simultaneous break and new NONSEQ: the reload wins; the flag still pulses.
- `HMASTER` ≥ `NMASTERS`: outputs are driven as master 0 with `HTRANS` forced to IDLE.

## Timing
- Address path latency: 0 cycles (combinational).
- Write-data select: the data phase follows the address phase by exactly one `HREADY`-high edge.
- Reset values (asynchronous, `HRESETn`=0): `dmaster`=0, `dvalid`=0, `beats_left`=0, `bmaster`=0, `BURST_BREAK`=0. Therefore `HMASTER_D`=0, `DVALID`=0, and `HWDATA` = master 0 data.
- Reset mid-burst clears the tracker; no `BURST_BREAK` is raised after release.
- Wait states: `HREADY`=0 for any number of cycles freezes all registers; `BURST_BREAK` stays 0.

## Configuration
- `AHB_MUX_IDLE_ON_NOGRANT_EN`:
  - Defined: when `HGRANTx`==0, `HTRANS` is forced to IDLE (2'b00) regardless of `HMASTER`. The tracker treats this as IDLE.
  - Undefined: `HGRANTx` is ignored and `HTRANS` always follows the `HMASTER`-selected master.

## Structure
- Shared package `ahb_pkg`:
  - `htrans_t` enum: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - `hburst_t` enum: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
  - `burst_len()` function.
  - Width constants.
- One sub-module, `ahb_burst_tracker`, holding `beats_left`, `bmaster` and `BURST_BREAK`.

## Test plan
- Reset: `HRESETn`=0 during traffic → `DVALID`=0, `HMASTER_D`=0, `BURST_BREAK`=0 immediately; all stay 0 one cycle after release with IDLE inputs.
- Pipelined write: `HMASTER`=3 NONSEQ then `HMASTER`=5, with `HREADY`=1 → next cycle `HMASTER_D`=3, `HWDATA`=`HWDATA_M`[3], `DVALID`=1.
- Wait states: `HREADY`=0 for 4 cycles mid data phase → `HMASTER_D`/`HWDATA` selection held, even though `HMASTER` changes to 7.
- Clean INCR4: master 2 NONSEQ+3 SEQ (with one BUSY inserted) → `BURST_BREAK` never asserts; `beats_left` ends at 0.
- Broken INCR8: master 1 issues NONSEQ+2 SEQ, then `HMASTER`=4 NONSEQ → `BURST_BREAK`=1 for exactly one cycle; tracker reloads for master 4.
- No grant: `HGRANTx`=0, `HMASTER`=6 with `HTRANS_M`[6]=NONSEQ → `HTRANS`=IDLE when `AHB_MUX_IDLE_ON_NOGRANT_EN` is defined, NONSEQ when it is undefined.
